// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl: SRAM exerciser / self-test controller.
// Writes a deterministic address-derived pattern to every SRAM location, reads
// each location back, compares, and reports pass/fail, a saturating mismatch
// count and the first failing address.
// Optional feature macro: SRAM_BIST_INV_PASS_EN adds a second write+read sweep
// with inverted data after the first sweep.
module sram_bist_ctrl #(
   parameter int                DATA_W    = 4,
   parameter int                ADDR_W    = 8,
   parameter logic [DATA_W-1:0] SEED      = '0,
   parameter int                ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 cs,
   output logic                 we,
   output logic                 oe,
   output logic [ADDR_W-1:0]    address,
   inout  wire  [DATA_W-1:0]    data,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [ADDR_W-1:0]    fail_addr
);

   // Width used to zero-extend the address before taking the low DATA_W bits
   localparam int EXT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

`ifdef SRAM_BIST_INV_PASS_EN
   localparam bit INV_PASS = 1'b1;
`else
   localparam bit INV_PASS = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR     = 3'd1,
      RD_ADR = 3'd2,
      RD_CMP = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t               state;
   logic                 pol;
   logic                 mismatch;
   logic [ERR_CNT_W-1:0] err_upd;

   // Expected SRAM word for an address under the current sweep polarity
   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic p);
      logic [EXT_W-1:0] ext;
      ext = EXT_W'(a);
      return ext[DATA_W-1:0] ^ SEED ^ {DATA_W{p}};
   endfunction

   // Error counter increment that sticks at all-ones
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // The bus is driven only during write cycles; oe and we are never both high
   assign data = we ? pattern(address, pol) : {DATA_W{1'bz}};

   // Read-back comparison and the error count it produces
   always_comb begin
      mismatch = 1'b0;
      err_upd  = err_count;
      if (state == RD_CMP && data != pattern(address, pol)) begin
         mismatch = 1'b1;
         err_upd  = sat_inc(err_count);
      end
   end

   // Test sequencer with registered SRAM strobes and status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pol       <= 1'b0;
         cs        <= 1'b0;
         we        <= 1'b0;
         oe        <= 1'b0;
         address   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               cs   <= 1'b0;
               we   <= 1'b0;
               oe   <= 1'b0;
               if (start) begin
                  state     <= WR;
                  pol       <= 1'b0;
                  busy      <= 1'b1;
                  err_count <= '0;
                  fail_addr <= '0;
                  address   <= '0;
                  cs        <= 1'b1;
                  we        <= 1'b1;
               end
            end
            WR: begin
               if (address == LAST_ADDR) begin
                  address <= '0;
                  state   <= RD_ADR;
                  we      <= 1'b0;
                  oe      <= 1'b1;
               end else begin
                  address <= address + 1'b1;
               end
            end
            RD_ADR: begin
               state <= RD_CMP;
            end
            RD_CMP: begin
               err_count <= err_upd;
               if (mismatch && err_count == '0)
                  fail_addr <= address;
               if (address != LAST_ADDR) begin
                  address <= address + 1'b1;
                  state   <= RD_ADR;
               end else if (INV_PASS && !pol) begin
                  // second sweep with inverted data
                  pol     <= 1'b1;
                  address <= '0;
                  state   <= WR;
                  we      <= 1'b1;
                  oe      <= 1'b0;
               end else begin
                  state   <= DONE;
                  address <= '0;
                  cs      <= 1'b0;
                  oe      <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= (err_upd == '0);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
